jk_bank_ctrl: RTL and testbench
===============================

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the width of the controlled JK flip-flop bank.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on posedge clk.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset (asserted when 0).
REQ-004 The block SHALL have port cmd_valid, input, 1, command offered.
REQ-005 The block SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high at posedge clk.
REQ-006 The block SHALL have port cmd_op, input, 3, operation code.
REQ-007 The block SHALL have port cmd_data, input, W, load value, toggle mask or serial-in bit (bit 0).
REQ-008 The block SHALL have port cmd_cnt, input, 4, iteration count for multi-cycle ops.
REQ-009 The block SHALL have port q_in, input, W, feedback of the current bank outputs.
REQ-010 The block SHALL have ports j and k, output, W each, per-bit drive to the bank.
REQ-011 The block SHALL have port busy, output, 1, high in EXEC.
REQ-012 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-013 FSM states: IDLE, EXEC, DONE; cmd_ready SHALL be high only in IDLE.
REQ-014 IDLE->EXEC on accept; op, data and cnt SHALL be latched; the iteration counter SHALL be loaded.
REQ-015 EXEC->DONE when the last iteration has been driven; DONE->IDLE unconditionally after 1 cycle.
REQ-016 j/k SHALL be combinational from state, latched op/data and q_in; outside EXEC, j=k=0 (bank holds).
REQ-017 Single-cycle ops, 1 EXEC cycle: 000 NOP j=k=0; 001 LOAD j=data, k=~data; 010 CLEAR j=0, k=all-1; 011 SET j=all-1, k=0; 100 TOGGLE j=k=data.
REQ-018 101 SHIFT-left, cnt EXEC cycles: next bit[i] = q_in[i-1] and next bit[0] = data[0]. Each bit SHALL be driven as a load: j=next, k=~next.
REQ-019 110 ROTATE-left, cnt EXEC cycles: next bit[0] = q_in[W-1], others as SHIFT, driven as a load.
REQ-020 111 COUNT-up, cnt EXEC cycles: j=k=t, where t[0]=1 and t[i]=&q_in[i-1:0]. The count SHALL wrap all-1 -> 0.
REQ-021 For op 101-111, cnt=0 SHALL skip EXEC (IDLE->DONE directly, j=k=0 throughout). Ops 000-100 SHALL ignore cnt.
REQ-022 Latency: accept at edge N; the first bank update at edge N+1; done high during the cycle after the last update; cmd_ready again after DONE.
REQ-023 cmd_valid and changes to cmd_* while not in IDLE SHALL be ignored; there SHALL be no queueing.
REQ-024 The iteration counter SHALL be 4 bits and decrement once per EXEC cycle, with no wrap (max 15 iterations).

Reset
REQ-025 While rst=0: state=IDLE, counter=0, latched op/data=0, busy=0, done=0, j=k=0, cmd_ready=1.
REQ-026 Reset asserted mid-EXEC or in DONE SHALL abort immediately with no done pulse. Bank contents already updated SHALL remain as-is, since the bank owns its own reset.
REQ-027 The first accept SHALL be possible at the first posedge after rst deasserts.

Verification
REQ-028 LOAD data=8'hA5 from q=00 -> one EXEC cycle with j=A5, k=5A; q=A5; done pulse 1 cycle later; cmd_ready back high.
REQ-029 COUNT cnt=3 from q=8'hFE -> j/k per cycle 01, FF, 01; q sequence FF, 00, 01; busy high exactly 3 cycles.
REQ-030 SHIFT cnt=4, data[0]=1 from q=8'h81 -> q=03, 07, 0F, 1F. ROTATE cnt=1 from q=8'h81 -> q=03.
REQ-031 ROTATE with cnt=0 -> no EXEC, j=k=0, done on the next cycle. cmd_valid held high during busy with a different op -> ignored.
REQ-032 rst pulled low in the 2nd EXEC cycle of COUNT cnt=5 -> busy=0, done=0, j=k=0 at once; cmd_ready=1 after release.
REQ-033 Back-to-back commands with cmd_valid held high -> accepts spaced by EXEC+2 cycles; TOGGLE mask=0F on q=F0 -> q=FF.

Source files
------------

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl
//
// Sequences per-bit J/K drive for an external bank of W JK flip-flops.
// A command (op, data, cnt) is accepted in IDLE. The block then spends one
// or more EXEC cycles driving j/k from the latched command and the bank's
// current outputs (q_in). It finishes with a single DONE cycle that pulses
// done. Outside EXEC, j = k = 0, so the bank holds its value.
//
// Handshake: a command transfers on a posedge where cmd_valid and cmd_ready
// are both high. cmd_ready is high only in IDLE. Anything offered on cmd_*
// while the block is not in IDLE is ignored, and nothing is queued.
//
// Ports
//   clk        single clock, all state updates on posedge
//   rst        asynchronous reset, active low
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (IDLE)
//   cmd_op     000 NOP, 001 LOAD, 010 CLEAR, 011 SET, 100 TOGGLE,
//              101 SHIFT-left, 110 ROTATE-left, 111 COUNT-up
//   cmd_data   load value / toggle mask / serial-in bit (bit 0)
//   cmd_cnt    iteration count for ops 101-111 (0 skips EXEC)
//   q_in       feedback of the bank outputs
//   j, k       per-bit drive to the bank
//   busy       high while in EXEC
//   done       one-cycle completion pulse (DONE state)
//   state_dbg  current FSM state, for observation only
module jk_bank_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  input  logic [3:0]   cmd_cnt,
  input  logic [W-1:0] q_in,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_CLEAR  = 3'b010;
  localparam logic [2:0] OP_SET    = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_SHIFT  = 3'b101;
  localparam logic [2:0] OP_ROTATE = 3'b110;
  localparam logic [2:0] OP_COUNT  = 3'b111;

  state_t       state, state_nxt;
  logic [2:0]   op_q;
  logic [W-1:0] data_q;
  logic [3:0]   cnt_q;

  logic         accept;
  logic         multi_op;
  logic         skip_exec;

  assign accept    = cmd_valid && (state == S_IDLE);
  // Ops 101..111 iterate cmd_cnt times. All other ops run exactly once.
  assign multi_op  = cmd_op[2] && (cmd_op[1] || cmd_op[0]);
  assign skip_exec = multi_op && (cmd_cnt == 4'd0);

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = skip_exec ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        // cnt_q holds the iterations still to drive, including this one.
        if (cnt_q <= 4'd1) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Command latch and iteration counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= 3'd0;
      data_q <= '0;
      cnt_q  <= 4'd0;
    end else if (accept) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
      cnt_q  <= multi_op ? cmd_cnt : 4'd1;
    end else if (state == S_EXEC && cnt_q != 4'd0) begin
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Bank drive
  // ---------------------------------------------------------------------
  logic [W-1:0] shift_nxt;
  logic [W-1:0] rot_nxt;
  logic [W-1:0] cnt_t;

  always_comb begin
    shift_nxt    = '0;
    rot_nxt      = '0;
    cnt_t        = '0;
    shift_nxt[0] = data_q[0];
    rot_nxt[0]   = q_in[W-1];
    cnt_t[0]     = 1'b1;
    for (int i = 1; i < W; i++) begin
      shift_nxt[i] = q_in[i-1];
      rot_nxt[i]   = q_in[i-1];
      // A bit toggles on count-up only when every lower bit is 1.
      cnt_t[i]     = cnt_t[i-1] & q_in[i-1];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (state == S_EXEC) begin
      case (op_q)
        OP_NOP: begin
          j = '0;
          k = '0;
        end
        OP_LOAD: begin
          j = data_q;
          k = ~data_q;
        end
        OP_CLEAR: begin
          j = '0;
          k = '1;
        end
        OP_SET: begin
          j = '1;
          k = '0;
        end
        OP_TOGGLE: begin
          j = data_q;
          k = data_q;
        end
        OP_SHIFT: begin
          j = shift_nxt;
          k = ~shift_nxt;
        end
        OP_ROTATE: begin
          j = rot_nxt;
          k = ~rot_nxt;
        end
        OP_COUNT: begin
          j = cnt_t;
          k = cnt_t;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_EXEC);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Testbench for jk_bank_ctrl. It models the JK bank around the DUT and feeds
// the bank outputs back on q_in. A reference model describes each operation
// by its arithmetic effect on the bank value, and every cycle is checked
// against that model.
module tb_jk_bank_ctrl;

  localparam int W = 8;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------------------------------------------------------------
  // DUT and bank
  // ---------------------------------------------------------------------
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op    = '0;
  logic [W-1:0] cmd_data  = '0;
  logic [3:0]   cmd_cnt   = '0;
  logic [W-1:0] j, k;
  logic         busy, done;
  logic [1:0]   state_dbg;

  logic [W-1:0] bank_q   = '0;
  logic         pre_en   = 1'b0;
  logic [W-1:0] pre_val  = '0;

  // The JK bank: it owns its own contents and is not reset by the DUT.
  always @(posedge clk) begin
    if (pre_en) bank_q <= pre_val;
    else        bank_q <= (j & ~bank_q) | (~k & bank_q);
  end

  jk_bank_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .q_in      (bank_q),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];   // expected bank values, one per EXEC cycle
  logic [W-1:0] mq;         // model's view of the bank value

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bank value after one iteration of an op.
  function automatic logic [W-1:0] ref_next(input logic [2:0] op, input logic [W-1:0] data,
                                            input logic [W-1:0] q);
    logic [W-1:0] r;
    case (op)
      3'd0: r = q;
      3'd1: r = data;
      3'd2: r = '0;
      3'd3: r = '1;
      3'd4: r = q ^ data;
      3'd5: begin r = q << 1; r[0] = data[0]; end
      3'd6: begin r = q << 1; r[0] = q[W-1]; end
      default: r = q + 1'b1;
    endcase
    return r;
  endfunction

  // j/k expected during an iteration. The load-style ops drive the next
  // value directly. TOGGLE and COUNT drive the bits that change. CLEAR and
  // SET use fixed patterns.
  task automatic ref_jk(input logic [2:0] op, input logic [W-1:0] data, input logic [W-1:0] q,
                        output logic [W-1:0] ej, output logic [W-1:0] ek);
    logic [W-1:0] nx;
    nx = ref_next(op, data, q);
    case (op)
      3'd0: begin ej = '0;       ek = '0;       end
      3'd2: begin ej = '0;       ek = '1;       end
      3'd3: begin ej = '1;       ek = '0;       end
      3'd4: begin ej = data;     ek = data;     end
      3'd7: begin ej = q ^ nx;   ek = q ^ nx;   end
      default: begin ej = nx;    ek = ~nx;      end
    endcase
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks (all called and returning on a negedge)
  // ---------------------------------------------------------------------
  task automatic set_bank(input logic [W-1:0] v);
    cmd_valid = 1'b0;
    pre_en  = 1'b1;
    pre_val = v;
    @(negedge clk);
    pre_en  = 1'b0;
    mq      = v;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offers a command and follows it to the end, checking every cycle.
  // noise: keep cmd_valid high with a different op while not in IDLE.
  // hold : leave cmd_valid high on return, so a following call is back-to-back.
  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] data, input logic [3:0] cnt,
                        input bit noise, input bit hold, output int acc_cyc);
    int n;
    logic [W-1:0] ej, ek, got_q;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    acc_cyc   = cycle;
    check("ready_at_offer", {31'd0, cmd_ready}, 1);
    n = (op >= 3'd5) ? int'(cnt) : 1;
    for (int i = 0; i < n; i++) exp_q.push_back('0);
    exp_q.delete();
    @(negedge clk);
    if (noise) begin
      cmd_op   = op + 3'(1 + $urandom_range(0, 6));
      cmd_data = W'($urandom);
      cmd_cnt  = 4'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      ref_jk(op, data, mq, ej, ek);
      check("exec_busy",  {31'd0, busy}, 1);
      check("exec_ready", {31'd0, cmd_ready}, 0);
      check("exec_done",  {31'd0, done}, 0);
      check("exec_j", 32'(j), 32'(ej));
      check("exec_k", 32'(k), 32'(ek));
      mq = ref_next(op, data, mq);
      exp_q.push_back(mq);
      @(negedge clk);
      got_q = bank_q;
      check("bank_q", 32'(got_q), 32'(exp_q.pop_front()));
    end
    check("done_pulse", {31'd0, done}, 1);
    check("done_busy",  {31'd0, busy}, 0);
    check("done_ready", {31'd0, cmd_ready}, 0);
    check("done_jk",    32'({j, k}), 0);
    @(negedge clk);
    check("idle_ready", {31'd0, cmd_ready}, 1);
    check("idle_done",  {31'd0, done}, 0);
    check("idle_busy",  {31'd0, busy}, 0);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int a0, a1, a2;
    logic [W-1:0] ej, ek;
    mq = '0;

    // Reset state.
    idle(3);
    check("rst_ready", {31'd0, cmd_ready}, 1);
    check("rst_busy",  {31'd0, busy}, 0);
    check("rst_done",  {31'd0, done}, 0);
    check("rst_j",     32'(j), 0);
    check("rst_k",     32'(k), 0);

    // First accept on the first posedge after release: LOAD A5 from 00.
    rst = 1'b1;
    do_cmd(3'd1, 8'hA5, 4'd0, 1'b0, 1'b0, a0);

    // COUNT x3 from FE.
    set_bank(8'hFE);
    do_cmd(3'd7, 8'h00, 4'd3, 1'b0, 1'b0, a0);
    check("count_final", 32'(bank_q), 32'h01);

    // SHIFT x4 from 81 with serial-in 1, then ROTATE x1 from 81.
    set_bank(8'h81);
    do_cmd(3'd5, 8'h01, 4'd4, 1'b0, 1'b0, a0);
    check("shift_final", 32'(bank_q), 32'h1F);
    set_bank(8'h81);
    do_cmd(3'd6, 8'h00, 4'd1, 1'b0, 1'b0, a0);
    check("rotate_final", 32'(bank_q), 32'h03);

    // ROTATE with cnt=0 skips EXEC. Noise while not idle is ignored.
    do_cmd(3'd6, 8'h00, 4'd0, 1'b1, 1'b0, a0);
    check("rot0_hold", 32'(bank_q), 32'h03);

    // Reset in the second EXEC cycle of COUNT x5.
    set_bank(8'h10);
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_data = '0; cmd_cnt = 4'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    ref_jk(3'd7, 8'h00, mq, ej, ek);
    check("abort_exec1_j", 32'(j), 32'(ej));
    mq = ref_next(3'd7, 8'h00, mq);
    @(negedge clk);
    check("abort_exec2_busy", {31'd0, busy}, 1);
    rst = 1'b0;
    #1;
    check("abort_busy",  {31'd0, busy}, 0);
    check("abort_done",  {31'd0, done}, 0);
    check("abort_jk",    32'({j, k}), 0);
    check("abort_ready", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    check("abort_no_done", {31'd0, done}, 0);
    check("abort_bank",    32'(bank_q), 32'(mq));
    rst = 1'b1;

    // Back-to-back commands with cmd_valid held high.
    set_bank(8'hF0);
    do_cmd(3'd4, 8'h0F, 4'd9, 1'b0, 1'b1, a0);
    check("toggle_final", 32'(bank_q), 32'hFF);
    do_cmd(3'd5, 8'h00, 4'd2, 1'b1, 1'b1, a1);
    do_cmd(3'd0, 8'h55, 4'd3, 1'b0, 1'b0, a2);
    check("b2b_space1", a1 - a0, 3);
    check("b2b_space2", a2 - a1, 4);

    // Randomized commands.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) set_bank(W'($urandom));
      do_cmd(3'($urandom_range(0, 7)), W'($urandom), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
